// File: rtl/ej32_rom_arb_if.sv
// Requester-side bus of the eJ32 ROM arbiter.
// Fetch and data request/ack/data signals.
interface ej32_rom_arb_if #(
    parameter int ASZ = 17
);
    logic           if_req;
    logic [ASZ-1:0] if_a;
    logic           if_ack;
    logic [7:0]     if_d;
    logic           dt_req;
    logic [ASZ-1:0] dt_a;
    logic           dt_w;
    logic           dt_ack;
    logic [31:0]    dt_d;

    modport master (
        output if_req, if_a, dt_req, dt_a, dt_w,
        input  if_ack, if_d, dt_ack, dt_d
    );

    modport slave (
        input  if_req, if_a, dt_req, dt_a, dt_w,
        output if_ack, if_d, dt_ack, dt_d
    );
endinterface

// File: rtl/ej32_rom_arb.sv
// Shares the 8-bit 1-cycle ROM port between fetch and data.
// Word reads are assembled big-endian from 4 byte reads.
module ej32_rom_arb #(
    parameter int ASZ    = 17,
    parameter int ROM_SZ = 8192
) (
    input  logic           clk,
    input  logic           rst,
    ej32_rom_arb_if.slave  bus,
    output logic [ASZ-1:0] rom_a,
    input  logic [7:0]     rom_d,
    output logic           busy
);
    if ((ROM_SZ & (ROM_SZ - 1)) != 0) begin : g_rom_sz_chk
        $error("ROM_SZ must be a power of two");
    end

    typedef enum logic [1:0] {
        IDLE,
        BYTE,
        WORD
    } state_t;

    state_t         state;
    state_t         nxt;
    logic [ASZ-1:0] a_r;
    logic [1:0]     cnt;
    logic [23:0]    sh;
    logic           last_dt;
    logic           tgt_dt;
    logic           if_el;
    logic           dt_el;
    logic           gnt_if;
    logic           gnt_dt;

    // A requester being acked this cycle is not a candidate.
    assign if_el = bus.if_req & ~bus.if_ack;
    assign dt_el = bus.dt_req & ~bus.dt_ack;
    assign busy  = (state != IDLE);

    // Grant, next state and ROM address selection.
    always_comb begin
        gnt_if = 1'b0;
        gnt_dt = 1'b0;
        nxt    = state;
        rom_a  = a_r;
        unique case (state)
            IDLE: begin
                if (dt_el && (!if_el || !last_dt)) begin
                    gnt_dt = 1'b1;
                    rom_a  = bus.dt_a;
                    nxt    = bus.dt_w ? WORD : BYTE;
                end else if (if_el) begin
                    gnt_if = 1'b1;
                    rom_a  = bus.if_a;
                    nxt    = BYTE;
                end
            end
            BYTE: nxt = IDLE;
            WORD: begin
                rom_a = a_r + ASZ'(cnt);
                if (cnt == 2'd0) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Grant bookkeeping, byte capture and ack generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= '0;
            cnt        <= 2'd0;
            sh         <= 24'h0;
            last_dt    <= 1'b0;
            tgt_dt     <= 1'b0;
            bus.if_ack <= 1'b0;
            bus.dt_ack <= 1'b0;
            bus.if_d   <= 8'h0;
            bus.dt_d   <= 32'h0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.dt_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_if || gnt_dt) begin
                        a_r     <= rom_a;
                        last_dt <= gnt_dt;
                        tgt_dt  <= gnt_dt;
                        cnt     <= (gnt_dt && bus.dt_w) ? 2'd1 : 2'd0;
                    end
                end
                BYTE: begin
                    if (tgt_dt) begin
                        bus.dt_ack <= 1'b1;
                        bus.dt_d   <= {24'h0, rom_d};
                    end else begin
                        bus.if_ack <= 1'b1;
                        bus.if_d   <= rom_d;
                    end
                end
                WORD: begin
                    cnt <= cnt + 2'd1;
                    sh  <= {sh[15:0], rom_d};
                    if (cnt == 2'd0) begin
                        bus.dt_ack <= 1'b1;
                        bus.dt_d   <= {sh, rom_d};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ej32_rom_arb.sv
// Bench for the eJ32 ROM arbiter: directed cases plus random
// traffic checked each cycle against a transaction-level model.
module tb_ej32_rom_arb;
    localparam int ASZ    = 17;
    localparam int ROM_SZ = 8192;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [ASZ-1:0] rom_a;
    logic [7:0]     rom_d = 8'h0;
    logic           busy;

    ej32_rom_arb_if #(.ASZ(ASZ)) bus();

    ej32_rom_arb #(.ASZ(ASZ), .ROM_SZ(ROM_SZ)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .rom_a (rom_a),
        .rom_d (rom_d),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [ROM_SZ];

    // Synchronous ROM, one cycle of latency.
    always @(posedge clk) rom_d <= rom[int'(rom_a) % ROM_SZ];

    int n_chk = 0;
    int n_err = 0;

    function automatic void check(string nm, logic [31:0] got,
                                  logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    function automatic logic [7:0] rb(logic [ASZ-1:0] a);
        return rom[int'(a) % ROM_SZ];
    endfunction

    // Transaction-level model: one transaction in flight at a time,
    // described by its grant cycle and fixed latency.
    int unsigned    cyc = 0;
    int unsigned    m_g = 0;
    int unsigned    m_l = 0;
    logic           m_act = 1'b0;
    logic           m_word = 1'b0;
    logic           m_dt = 1'b0;
    logic           m_last_dt = 1'b0;
    logic [ASZ-1:0] m_addr = '0;
    logic [ASZ-1:0] m_last_a = '0;
    logic [31:0]    m_data = '0;
    logic [31:0]    m_dt_d = '0;
    logic [7:0]     m_if_d = '0;

    task automatic model_step();
        logic           e_if_ack, e_dt_ack, e_busy;
        logic           if_el, dt_el, win_dt;
        logic [ASZ-1:0] e_a, ga;
        int unsigned    k;
        cyc++;
        if (rst) begin
            m_act     = 1'b0;
            m_last_dt = 1'b0;
            m_last_a  = '0;
            m_if_d    = '0;
            m_dt_d    = '0;
            return;
        end
        e_if_ack = m_act && !m_dt && (cyc == m_g + m_l);
        e_dt_ack = m_act &&  m_dt && (cyc == m_g + m_l);
        if (e_if_ack) m_if_d = m_data[7:0];
        if (e_dt_ack) m_dt_d = m_data;
        if (m_act && cyc >= m_g + m_l) m_act = 1'b0;
        e_busy = m_act;
        e_a = m_last_a;
        if (m_act && m_word) begin
            k = cyc - m_g;
            if (k >= 1 && k <= 3) e_a = ASZ'(m_addr + k);
        end
        if (!m_act) begin
            if_el = bus.if_req && !e_if_ack;
            dt_el = bus.dt_req && !e_dt_ack;
            if (if_el || dt_el) begin
                win_dt    = dt_el && !(if_el && m_last_dt);
                ga        = win_dt ? bus.dt_a : bus.if_a;
                m_word    = win_dt && bus.dt_w;
                m_dt      = win_dt;
                m_addr    = ga;
                m_g       = cyc;
                m_l       = m_word ? 5 : 2;
                m_act     = 1'b1;
                m_last_dt = win_dt;
                m_last_a  = ga;
                e_a       = ga;
                if (m_word)
                    m_data = {rb(ga), rb(ASZ'(ga + 1)),
                              rb(ASZ'(ga + 2)), rb(ASZ'(ga + 3))};
                else
                    m_data = {24'h0, rb(ga)};
            end
        end
        check("m_rom_a", 32'(rom_a), 32'(e_a));
        check("m_busy", 32'(busy), 32'(e_busy));
        check("m_if_ack", 32'(bus.if_ack), 32'(e_if_ack));
        check("m_dt_ack", 32'(bus.dt_ack), 32'(e_dt_ack));
        check("m_if_d", 32'(bus.if_d), 32'(m_if_d));
        check("m_dt_d", bus.dt_d, m_dt_d);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.if_req = 1'b0;
        bus.if_a   = '0;
        bus.dt_req = 1'b0;
        bus.dt_a   = '0;
        bus.dt_w   = 1'b0;
    endtask

    task automatic word_rd(input logic [ASZ-1:0] a,
                           input logic [31:0] exp, input string nm);
        int acks = 0;
        bus.dt_req = 1'b1;
        bus.dt_w   = 1'b1;
        bus.dt_a   = a;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 4) check({nm, "_rom_a"}, 32'(rom_a), 32'(ASZ'(a + k)));
            if (k == 5) begin
                check({nm, "_ack_t5"}, 32'(bus.dt_ack), 32'd1);
                check({nm, "_data"}, bus.dt_d, exp);
            end
            if (bus.dt_ack) acks++;
            tick();
            if (k == 5) bus.dt_req = 1'b0;
        end
        check({nm, "_ack_count"}, 32'(acks), 32'd1);
    endtask

    function automatic logic [ASZ-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return ASZ'($urandom_range(0, 63));
            1:       return ASZ'(32'h1FFC + $urandom_range(0, 7));
            2:       return ASZ'(32'h1FFFC + $urandom_range(0, 3));
            default: return ASZ'($urandom);
        endcase
    endfunction

    logic [8:0] ia, da;
    int         n_dtack;
    logic       if_seen = 1'b0;
    logic       dt_seen = 1'b0;

    initial begin
        for (int i = 0; i < ROM_SZ; i++) rom[i] = 8'($urandom);
        rom[16'h0010] = 8'hA5;
        rom[16'h0042] = 8'h9C;
        rom[16'h0100] = 8'h12;
        rom[16'h0101] = 8'h34;
        rom[16'h0102] = 8'h56;
        rom[16'h0103] = 8'h78;
        rom[16'h1FFF] = 8'hDE;
        rom[16'h0000] = 8'hAD;
        rom[16'h0001] = 8'hBE;
        rom[16'h0002] = 8'hEF;
        idle_bus();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_if_ack", 32'(bus.if_ack), 32'd0);
        check("rst_dt_ack", 32'(bus.dt_ack), 32'd0);
        check("rst_if_d", 32'(bus.if_d), 32'd0);
        check("rst_dt_d", bus.dt_d, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_a", 32'(rom_a), 32'd0);

        // Byte fetch.
        tick();
        bus.if_req = 1'b1;
        bus.if_a   = 17'h10;
        @(negedge clk);
        check("bf_rom_a_t0", 32'(rom_a), 32'h10);
        tick();
        @(negedge clk);
        check("bf_busy_t1", 32'(busy), 32'd1);
        check("bf_ack_t1", 32'(bus.if_ack), 32'd0);
        tick();
        @(negedge clk);
        check("bf_ack_t2", 32'(bus.if_ack), 32'd1);
        check("bf_if_d", 32'(bus.if_d), 32'hA5);
        check("bf_busy_t2", 32'(busy), 32'd0);
        tick();
        bus.if_req = 1'b0;
        tick();

        // Word read.
        word_rd(17'h100, 32'h12345678, "wd");

        // Byte data read.
        bus.dt_req = 1'b1;
        bus.dt_w   = 1'b0;
        bus.dt_a   = 17'h42;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        check("bd_ack_t2", 32'(bus.dt_ack), 32'd1);
        check("bd_dt_d", bus.dt_d, 32'h0000009C);
        check("bd_if_d", 32'(bus.if_d), 32'hA5);
        check("bd_if_ack", 32'(bus.if_ack), 32'd0);
        tick();
        bus.dt_req = 1'b0;
        tick();

        // Word read that crosses the ROM size boundary.
        word_rd(17'h1FFF, 32'hDEADBEEF, "wrap");

        // Reset in the middle of a word read.
        bus.dt_req = 1'b1;
        bus.dt_w   = 1'b1;
        bus.dt_a   = 17'h300;
        tick();
        tick();
        rst        = 1'b1;
        bus.dt_req = 1'b0;
        tick();
        rst        = 1'b0;
        bus.if_req = 1'b1;
        bus.if_a   = 17'h10;
        @(negedge clk);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_dt_d", bus.dt_d, 32'd0);
        check("rm_rom_a", 32'(rom_a), 32'h10);
        n_dtack = int'(bus.dt_ack);
        tick();
        @(negedge clk);
        check("rm_if_ack_t1", 32'(bus.if_ack), 32'd0);
        n_dtack += int'(bus.dt_ack);
        tick();
        @(negedge clk);
        check("rm_if_ack_t2", 32'(bus.if_ack), 32'd1);
        check("rm_if_d", 32'(bus.if_d), 32'hA5);
        n_dtack += int'(bus.dt_ack);
        tick();
        bus.if_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_dtack += int'(bus.dt_ack);
            tick();
        end
        check("rm_no_dt_ack", 32'(n_dtack), 32'd0);

        // Contention straight out of reset.
        rst = 1'b1;
        idle_bus();
        tick();
        rst        = 1'b0;
        bus.if_req = 1'b1;
        bus.if_a   = 17'h10;
        bus.dt_req = 1'b1;
        bus.dt_w   = 1'b0;
        bus.dt_a   = 17'h42;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            ia[k] = bus.if_ack;
            da[k] = bus.dt_ack;
            tick();
        end
        check("ct_if_acks", 32'(ia), 32'h110);
        check("ct_dt_acks", 32'(da), 32'h044);
        rst = 1'b1;
        idle_bus();
        tick();
        rst = 1'b0;

        // Random traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if (bus.if_ack) begin
                if_seen = 1'b1;
            end else if (if_seen) begin
                if_seen = 1'b0;
                if ($urandom_range(0, 2) != 0) begin
                    bus.if_req = 1'b1;
                    bus.if_a   = rand_addr();
                end else begin
                    bus.if_req = 1'b0;
                end
            end else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
                bus.if_req = 1'b1;
                bus.if_a   = rand_addr();
            end
            if (bus.dt_ack) begin
                dt_seen = 1'b1;
            end else if (dt_seen) begin
                dt_seen = 1'b0;
                if ($urandom_range(0, 2) != 0) begin
                    bus.dt_req = 1'b1;
                    bus.dt_a   = rand_addr();
                    bus.dt_w   = 1'($urandom_range(0, 1));
                end else begin
                    bus.dt_req = 1'b0;
                end
            end else if (!bus.dt_req && $urandom_range(0, 3) == 0) begin
                bus.dt_req = 1'b1;
                bus.dt_a   = rand_addr();
                bus.dt_w   = 1'($urandom_range(0, 1));
            end
            tick();
        end
        idle_bus();
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
